// File: rtl/cmp_thresh_arbiter.sv
// rtl/cmp_thresh_arbiter.sv - round-robin shared bit-serial operand > THRESH comparator
// Optional build macro: CMP_ARB_EARLY_EXIT_EN (leave CMP at the deciding bit)
`timescale 1ns/1ps
module cmp_thresh_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 6,
  parameter int THRESH  = 19
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*WIDTH-1:0]   i_operand,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_busy,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_res_id,
  output logic                       o_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    id_q;
  logic [WIDTH-1:0] op_q;
  logic [BW-1:0]    bit_idx;
  logic             decided;
  logic             result_q;

  logic             pick_found;
  logic [IW-1:0]    pick_id;
  logic [IW-1:0]    ptr_next;
  logic [WIDTH-1:0] pick_op;
  logic             last_bit;
  logic             differ;
  logic             cur_op;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    logic [IW-1:0] cand_w;
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    cand_w     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_w = IW'(cand);
      if (!pick_found && i_req[cand_w]) begin
        pick_found = 1'b1;
        pick_id    = cand_w;
      end
    end
  end

  always_comb begin
    pick_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_id == IW'(k)) pick_op = i_operand[k*WIDTH +: WIDTH];
    end
    ptr_next = (pick_id == IW'(NUM_REQ-1)) ? '0 : pick_id + 1'b1;
  end

  assign last_bit = (bit_idx == '0);
  assign cur_op   = op_q[bit_idx];
  assign differ   = !decided && (cur_op != THR[bit_idx]);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pick_found) state_next = CMP;
      CMP: begin
`ifdef CMP_ARB_EARLY_EXIT_EN
        if (differ || last_bit) state_next = DONE;
`else
        if (last_bit) state_next = DONE;
`endif
      end
      DONE: if (i_res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      id_q     <= '0;
      op_q     <= '0;
      bit_idx  <= '0;
      decided  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (pick_found) begin
          op_q     <= pick_op;
          id_q     <= pick_id;
          ptr      <= ptr_next;
          bit_idx  <= BW'(WIDTH-1);
          decided  <= 1'b0;
          result_q <= 1'b0;
        end
        CMP: begin
          // Only the most significant differing bit decides the result.
          if (differ) begin
            decided  <= 1'b1;
            result_q <= cur_op;
          end
          if (!last_bit) bit_idx <= bit_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Grant is combinational so the capture happens in the arbitration cycle; held off during reset.
  assign o_grant     = (i_rst_n && state == IDLE && pick_found) ? (NUM_REQ'(1) << pick_id) : '0;
  assign o_busy      = (state != IDLE);
  assign o_res_valid = (state == DONE);
  assign o_res_id    = o_res_valid ? id_q : '0;
  assign o_result    = o_res_valid ? result_q : 1'b0;

endmodule
